// File: rtl/vr_log_space_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vr_log_space_ctrl
// Description : Head/tail allocator for the VR replica header and data log
//               rings; arbitrates flush, free and append requests.
// Revision    : 1.0 - initial release
// ============================================================================
module vr_log_space_ctrl #(
    parameter int HDR_DEPTH_W  = 11,
    parameter int DATA_DEPTH_W = 11
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alloc_req_val,
    input  logic [DATA_DEPTH_W:0]   alloc_req_data_lines,
    output logic                    alloc_req_rdy,
    output logic                    alloc_resp_val,
    output logic [HDR_DEPTH_W-1:0]  alloc_resp_hdr_addr,
    output logic [DATA_DEPTH_W-1:0] alloc_resp_data_addr,
    input  logic                    alloc_resp_rdy,
    input  logic                    free_req_val,
    input  logic [DATA_DEPTH_W:0]   free_req_data_lines,
    output logic                    free_req_rdy,
    input  logic                    flush_req_val,
    output logic                    flush_req_rdy,
    output logic [HDR_DEPTH_W:0]    hdr_log_head,
    output logic [HDR_DEPTH_W:0]    hdr_log_tail,
    output logic [DATA_DEPTH_W:0]   data_log_head,
    output logic [DATA_DEPTH_W:0]   data_log_tail,
    output logic [HDR_DEPTH_W:0]    hdr_used,
    output logic [DATA_DEPTH_W:0]   data_free
);

    localparam logic [0:0] c_ST_IDLE       = 1'b0;
    localparam logic [0:0] c_ST_ALLOC_RESP = 1'b1;
    localparam logic [DATA_DEPTH_W:0] c_DATA_CAP = {1'b1, {DATA_DEPTH_W{1'b0}}};
    localparam logic [HDR_DEPTH_W:0]  c_HDR_ONE  = {{HDR_DEPTH_W{1'b0}}, 1'b1};

    logic [0:0]              r_state;
    logic [HDR_DEPTH_W:0]    r_hdr_head;
    logic [HDR_DEPTH_W:0]    r_hdr_tail;
    logic [DATA_DEPTH_W:0]   r_data_head;
    logic [DATA_DEPTH_W:0]   r_data_tail;
    logic                    r_resp_val;
    logic [HDR_DEPTH_W-1:0]  r_resp_hdr_addr;
    logic [DATA_DEPTH_W-1:0] r_resp_data_addr;

    logic [HDR_DEPTH_W:0]  w_hdr_used;
    logic [DATA_DEPTH_W:0] w_data_used;
    logic [DATA_DEPTH_W:0] w_data_free;
    logic                  w_hdr_empty;
    logic                  w_hdr_full;
    logic                  w_idle;
    logic                  w_free_ok;
    logic                  w_flush_acc;
    logic                  w_free_acc;
    logic                  w_alloc_acc;

    assign w_hdr_used  = r_hdr_tail - r_hdr_head;
    assign w_data_used = r_data_tail - r_data_head;
    assign w_data_free = c_DATA_CAP - w_data_used;
    assign w_hdr_empty = (r_hdr_tail == r_hdr_head);
    assign w_hdr_full  = (r_hdr_tail[HDR_DEPTH_W-1:0] == r_hdr_head[HDR_DEPTH_W-1:0]) &&
                         (r_hdr_tail[HDR_DEPTH_W] != r_hdr_head[HDR_DEPTH_W]);

    // A free that cannot be taken (empty ring) does not block a pending append.
    assign w_idle      = (r_state == c_ST_IDLE) && !rst;
    assign w_free_ok   = free_req_val && !w_hdr_empty;
    assign w_flush_acc = w_idle && flush_req_val;
    assign w_free_acc  = w_idle && !flush_req_val && w_free_ok;
    assign w_alloc_acc = w_idle && !flush_req_val && !w_free_ok && alloc_req_val &&
                         !w_hdr_full && (w_data_free >= alloc_req_data_lines);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= c_ST_IDLE;
            r_hdr_head       <= '0;
            r_hdr_tail       <= '0;
            r_data_head      <= '0;
            r_data_tail      <= '0;
            r_resp_val       <= 1'b0;
            r_resp_hdr_addr  <= '0;
            r_resp_data_addr <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_flush_acc) begin
                        r_hdr_head  <= '0;
                        r_hdr_tail  <= '0;
                        r_data_head <= '0;
                        r_data_tail <= '0;
                    end else if (w_free_acc) begin
                        r_hdr_head  <= r_hdr_head + c_HDR_ONE;
                        r_data_head <= r_data_head + free_req_data_lines;
                    end else if (w_alloc_acc) begin
                        r_resp_hdr_addr  <= r_hdr_tail[HDR_DEPTH_W-1:0];
                        r_resp_data_addr <= r_data_tail[DATA_DEPTH_W-1:0];
                        r_hdr_tail       <= r_hdr_tail + c_HDR_ONE;
                        r_data_tail      <= r_data_tail + alloc_req_data_lines;
                        r_resp_val       <= 1'b1;
                        r_state          <= c_ST_ALLOC_RESP;
                    end
                end
                c_ST_ALLOC_RESP: begin
                    if (alloc_resp_rdy) begin
                        r_resp_val <= 1'b0;
                        r_state    <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_resp_val <= 1'b0;
                    r_state    <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign alloc_req_rdy        = w_alloc_acc;
    assign free_req_rdy         = w_free_acc;
    assign flush_req_rdy        = w_flush_acc;
    assign alloc_resp_val       = r_resp_val;
    assign alloc_resp_hdr_addr  = r_resp_hdr_addr;
    assign alloc_resp_data_addr = r_resp_data_addr;
    assign hdr_log_head         = r_hdr_head;
    assign hdr_log_tail         = r_hdr_tail;
    assign data_log_head        = r_data_head;
    assign data_log_tail        = r_data_tail;
    assign hdr_used             = w_hdr_used;
    assign data_free            = w_data_free;

endmodule
`default_nettype wire

// File: tb/tb_vr_log_space_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vr_log_space_ctrl
// Description : Self-checking bench for vr_log_space_ctrl (full-size and
//               small-ring instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vr_log_space_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    // Full-size instance (11/11)
    logic        b_alloc_val, b_alloc_rdy, b_resp_val, b_resp_rdy;
    logic [11:0] b_alloc_lines, b_free_lines;
    logic [10:0] b_resp_haddr, b_resp_daddr;
    logic        b_free_val, b_free_rdy, b_flush_val, b_flush_rdy;
    logic [11:0] b_hhead, b_htail, b_dhead, b_dtail, b_hused, b_dfree;

    // Small instance: 4 header slots, 8 data lines
    logic       s_alloc_val, s_alloc_rdy, s_resp_val, s_resp_rdy;
    logic [3:0] s_alloc_lines, s_free_lines;
    logic [1:0] s_resp_haddr;
    logic [2:0] s_resp_daddr;
    logic       s_free_val, s_free_rdy, s_flush_val, s_flush_rdy;
    logic [2:0] s_hhead, s_htail, s_hused;
    logic [3:0] s_dhead, s_dtail, s_dfree;

    vr_log_space_ctrl u_big (
        .clk(clk), .rst(rst),
        .alloc_req_val(b_alloc_val), .alloc_req_data_lines(b_alloc_lines), .alloc_req_rdy(b_alloc_rdy),
        .alloc_resp_val(b_resp_val), .alloc_resp_hdr_addr(b_resp_haddr), .alloc_resp_data_addr(b_resp_daddr),
        .alloc_resp_rdy(b_resp_rdy),
        .free_req_val(b_free_val), .free_req_data_lines(b_free_lines), .free_req_rdy(b_free_rdy),
        .flush_req_val(b_flush_val), .flush_req_rdy(b_flush_rdy),
        .hdr_log_head(b_hhead), .hdr_log_tail(b_htail), .data_log_head(b_dhead), .data_log_tail(b_dtail),
        .hdr_used(b_hused), .data_free(b_dfree)
    );

    vr_log_space_ctrl #(.HDR_DEPTH_W(2), .DATA_DEPTH_W(3)) u_small (
        .clk(clk), .rst(rst),
        .alloc_req_val(s_alloc_val), .alloc_req_data_lines(s_alloc_lines), .alloc_req_rdy(s_alloc_rdy),
        .alloc_resp_val(s_resp_val), .alloc_resp_hdr_addr(s_resp_haddr), .alloc_resp_data_addr(s_resp_daddr),
        .alloc_resp_rdy(s_resp_rdy),
        .free_req_val(s_free_val), .free_req_data_lines(s_free_lines), .free_req_rdy(s_free_rdy),
        .flush_req_val(s_flush_val), .flush_req_rdy(s_flush_rdy),
        .hdr_log_head(s_hhead), .hdr_log_tail(s_htail), .data_log_head(s_dhead), .data_log_tail(s_dtail),
        .hdr_used(s_hused), .data_free(s_dfree)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester-side legality: frees never exceed data in use, appends never exceed ring size.
    always @(posedge clk) begin
        if (!rst && s_free_val && s_free_rdy)
            assert (s_free_lines <= 4'(s_dtail - s_dhead)) else $error("illegal small free");
        if (!rst && s_alloc_val)
            assert (s_alloc_lines <= 4'd8) else $error("illegal small alloc");
        if (!rst && b_alloc_val)
            assert (b_alloc_lines <= 12'd2048) else $error("illegal big alloc");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // op: 0 alloc, 1 free, 2 flush+free+alloc, 3 free+alloc
    typedef struct {
        int op; int alines; int flines; int exp_rdy; int haddr; int daddr;
        int htail; int hhead; int dtail; int dhead; int hused; int dfree;
    } vec_t;

    function automatic vec_t mk(int op, int al, int fl, int r, int ha, int da,
                                int ht, int hh, int dt, int dh, int hu, int df);
        vec_t v;
        v.op = op; v.alines = al; v.flines = fl; v.exp_rdy = r; v.haddr = ha; v.daddr = da;
        v.htail = ht; v.hhead = hh; v.dtail = dt; v.dhead = dh; v.hused = hu; v.dfree = df;
        return v;
    endfunction

    task automatic s_resp_handshake(input int haddr, input int daddr);
        chk("s_resp_val", 32'(s_resp_val), 1);
        chk("s_resp_haddr", 32'(s_resp_haddr), 32'(haddr));
        chk("s_resp_daddr", 32'(s_resp_daddr), 32'(daddr));
        s_resp_rdy = 1'b1;
        @(posedge clk); #1;
        s_resp_rdy = 1'b0;
        chk("s_resp_val_drop", 32'(s_resp_val), 0);
    endtask

    // Append on the full-size instance; optionally leaves the response pending.
    task automatic b_alloc(input int lines, input int haddr, input int daddr, input bit consume);
        @(negedge clk);
        b_alloc_val = 1'b1; b_alloc_lines = 12'(lines);
        #1 chk("b_alloc_rdy", 32'(b_alloc_rdy), 1);
        @(posedge clk); #1;
        b_alloc_val = 1'b0;
        chk("b_resp_val", 32'(b_resp_val), 1);
        chk("b_resp_haddr", 32'(b_resp_haddr), 32'(haddr));
        chk("b_resp_daddr", 32'(b_resp_daddr), 32'(daddr));
        if (consume) begin
            b_resp_rdy = 1'b1;
            @(posedge clk); #1;
            b_resp_rdy = 1'b0;
            chk("b_resp_val_drop", 32'(b_resp_val), 0);
        end
    endtask

    vec_t vecs[16];

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1;
        {b_alloc_val, b_resp_rdy, b_free_val, b_flush_val} = '0;
        {s_alloc_val, s_resp_rdy, s_free_val, s_flush_val} = '0;
        b_alloc_lines = '0; b_free_lines = '0; s_alloc_lines = '0; s_free_lines = '0;

        vecs[0]  = mk(0, 5, 0, 1, 0, 0, 1, 0, 5, 0, 1, 3);
        vecs[1]  = mk(0, 4, 0, 0, 0, 0, 1, 0, 5, 0, 1, 3);
        vecs[2]  = mk(1, 0, 5, 1, 0, 0, 1, 1, 5, 5, 0, 8);
        vecs[3]  = mk(0, 4, 0, 1, 1, 5, 2, 1, 9, 5, 1, 4);
        vecs[4]  = mk(1, 0, 4, 1, 0, 0, 2, 2, 9, 9, 0, 8);
        vecs[5]  = mk(1, 0, 0, 0, 0, 0, 2, 2, 9, 9, 0, 8);
        vecs[6]  = mk(0, 0, 0, 1, 2, 1, 3, 2, 9, 9, 1, 8);
        vecs[7]  = mk(0, 0, 0, 1, 3, 1, 4, 2, 9, 9, 2, 8);
        vecs[8]  = mk(0, 0, 0, 1, 0, 1, 5, 2, 9, 9, 3, 8);
        vecs[9]  = mk(0, 0, 0, 1, 1, 1, 6, 2, 9, 9, 4, 8);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 6, 2, 9, 9, 4, 8);
        vecs[11] = mk(1, 0, 0, 1, 0, 0, 6, 3, 9, 9, 3, 8);
        vecs[12] = mk(0, 8, 0, 1, 2, 1, 7, 3, 1, 9, 4, 0);
        vecs[13] = mk(1, 0, 8, 1, 0, 0, 7, 4, 1, 1, 3, 8);
        vecs[14] = mk(2, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 8);
        vecs[15] = mk(3, 2, 1, 1, 0, 0, 1, 0, 2, 0, 1, 6);

        #22 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_hhead", 32'(b_hhead), 0);
        chk("rst_htail", 32'(b_htail), 0);
        chk("rst_dhead", 32'(b_dhead), 0);
        chk("rst_dtail", 32'(b_dtail), 0);
        chk("rst_hused", 32'(b_hused), 0);
        chk("rst_dfree", 32'(b_dfree), 2048);
        chk("rst_resp_val", 32'(b_resp_val), 0);

        // Two 3-line appends
        b_alloc(3, 0, 0, 1'b1);
        b_alloc(3, 1, 3, 1'b1);
        chk("b_dtail_6", 32'(b_dtail), 6);
        chk("b_dfree_2042", 32'(b_dfree), 2042);
        chk("b_htail_2", 32'(b_htail), 2);

        // Small-ring vector table
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            s_alloc_val   = (vecs[i].op == 0) || (vecs[i].op >= 2);
            s_free_val    = (vecs[i].op >= 1);
            s_flush_val   = (vecs[i].op == 2);
            s_alloc_lines = 4'(vecs[i].alines);
            s_free_lines  = 4'(vecs[i].flines);
            #1;
            case (vecs[i].op)
                0: chk($sformatf("v%0d_alloc_rdy", i), 32'(s_alloc_rdy), 32'(vecs[i].exp_rdy));
                1: chk($sformatf("v%0d_free_rdy", i), 32'(s_free_rdy), 32'(vecs[i].exp_rdy));
                2: begin
                    chk($sformatf("v%0d_flush_rdy", i), 32'(s_flush_rdy), 1);
                    chk($sformatf("v%0d_free_rdy", i), 32'(s_free_rdy), 0);
                    chk($sformatf("v%0d_alloc_rdy", i), 32'(s_alloc_rdy), 0);
                end
                default: begin
                    chk($sformatf("v%0d_free_rdy", i), 32'(s_free_rdy), 0);
                    chk($sformatf("v%0d_alloc_rdy", i), 32'(s_alloc_rdy), 32'(vecs[i].exp_rdy));
                end
            endcase
            @(posedge clk); #1;
            {s_alloc_val, s_free_val, s_flush_val} = '0;
            if ((vecs[i].op == 0 || vecs[i].op == 3) && vecs[i].exp_rdy == 1)
                s_resp_handshake(vecs[i].haddr, vecs[i].daddr);
            chk($sformatf("v%0d_htail", i), 32'(s_htail), 32'(vecs[i].htail));
            chk($sformatf("v%0d_hhead", i), 32'(s_hhead), 32'(vecs[i].hhead));
            chk($sformatf("v%0d_dtail", i), 32'(s_dtail), 32'(vecs[i].dtail));
            chk($sformatf("v%0d_dhead", i), 32'(s_dhead), 32'(vecs[i].dhead));
            chk($sformatf("v%0d_hused", i), 32'(s_hused), 32'(vecs[i].hused));
            chk($sformatf("v%0d_dfree", i), 32'(s_dfree), 32'(vecs[i].dfree));
        end

        // Held append stalls behind a free, then goes through once space returns
        @(negedge clk);
        s_alloc_val = 1'b1; s_alloc_lines = 4'd7;
        s_free_val  = 1'b1; s_free_lines  = 4'd2;
        #1;
        chk("hold_free_rdy", 32'(s_free_rdy), 1);
        chk("hold_alloc_rdy0", 32'(s_alloc_rdy), 0);
        @(posedge clk); #1;
        s_free_val = 1'b0;
        chk("hold_alloc_rdy1", 32'(s_alloc_rdy), 1);
        @(posedge clk); #1;
        s_alloc_val = 1'b0;
        s_resp_handshake(1, 2);
        chk("hold_dtail", 32'(s_dtail), 9);

        // Response held 5 cycles; competing flush/free/alloc must wait
        b_alloc(1, 2, 6, 1'b0);
        b_flush_val = 1'b1; b_free_val = 1'b1; b_free_lines = 12'd0;
        b_alloc_val = 1'b1; b_alloc_lines = 12'd1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_resp_val", 32'(b_resp_val), 1);
            chk("hold_resp_haddr", 32'(b_resp_haddr), 2);
            chk("hold_resp_daddr", 32'(b_resp_daddr), 6);
            chk("hold_flush_rdy", 32'(b_flush_rdy), 0);
            chk("hold_free_rdy_b", 32'(b_free_rdy), 0);
            chk("hold_alloc_rdy_b", 32'(b_alloc_rdy), 0);
        end
        b_resp_rdy = 1'b1;
        @(posedge clk); #1;
        b_resp_rdy = 1'b0;
        chk("late_resp_drop", 32'(b_resp_val), 0);
        chk("late_flush_rdy", 32'(b_flush_rdy), 1);
        @(posedge clk); #1;
        {b_flush_val, b_free_val, b_alloc_val} = '0;
        chk("flush_htail", 32'(b_htail), 0);
        chk("flush_dtail", 32'(b_dtail), 0);
        chk("flush_hhead", 32'(b_hhead), 0);

        // Async reset while a response is pending
        b_alloc(4, 0, 0, 1'b0);
        chk("pre_rst_dtail", 32'(b_dtail), 4);
        @(negedge clk);
        #2;
        b_alloc_val = 1'b1; b_alloc_lines = 12'd1;
        rst = 1'b1;
        #1;
        chk("arst_resp_val", 32'(b_resp_val), 0);
        chk("arst_htail", 32'(b_htail), 0);
        chk("arst_dtail", 32'(b_dtail), 0);
        chk("arst_dfree", 32'(b_dfree), 2048);
        chk("arst_alloc_rdy", 32'(b_alloc_rdy), 0);
        @(posedge clk); #2;
        rst = 1'b0;
        b_alloc_val = 1'b0;
        b_alloc(2, 0, 0, 1'b1);
        chk("post_rst_dtail", 32'(b_dtail), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
